// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with stall, flush and
// saturating transfer/stall statistics.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic [CNT_W-1:0]  r_xfer_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  // Reset forces the empty view on the outputs before the first edge lands.
  always_comb begin
    w_in_ready  = !stall && (Rst || (r_state != S_TWO));
    w_out_valid = !Rst && !stall && (r_state != S_EMPTY);
    w_in_fire   = in_valid && w_in_ready;
    w_out_fire  = w_out_valid && out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = NOP_VALUE;
      w_skid_nxt  = NOP_VALUE;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = S_TWO;
          end else if (w_out_fire) begin
            w_main_nxt  = NOP_VALUE;
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP_VALUE;
            w_state_nxt = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = NOP_VALUE;
          w_skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      // Counters saturate and survive flush.
      if (w_out_fire && !flush && (r_xfer_cnt != '1))
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      if (stall && !flush && (r_state != S_EMPTY) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_out_valid;
    out_data  = (Rst || (r_state == S_EMPTY)) ? NOP_VALUE : r_main;
    occupancy = Rst ? 2'd0 : r_state;
    xfer_cnt  = r_xfer_cnt;
    stall_cnt = r_stall_cnt;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width in bits.
REQ-002 The block SHALL have parameter NOP_VALUE, default {DATA_W{1'b0}}: payload value held whenever no entry is stored (bubble).
REQ-003 The block SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-004 Port Clk  input  1: the single clock; all state updates occur on its rising edge.
REQ-005 Port Rst  input  1: reset, synchronous and active-high.
REQ-006 Port in_valid  input  1: the upstream stage offers in_data this cycle.
REQ-007 Port in_data  input  DATA_W: upstream payload, such as an instruction word, PC+4 or control bundle.
REQ-008 Port in_ready  output  1: the stage accepts in_data this cycle.
REQ-009 Port out_valid  output  1: out_data holds a valid entry.
REQ-010 Port out_data  output  DATA_W: the oldest stored entry.
REQ-011 Port out_ready  input  1: the downstream stage accepts out_data this cycle.
REQ-012 Port stall  input  1: hazard-unit hold; while high, this stage makes no transfers.
REQ-013 Port flush  input  1: branch/jump squash; discards all stored entries.
REQ-014 Port occupancy  output  2: number of stored entries, 0 to 2.
REQ-015 Port xfer_cnt  output  CNT_W: count of output transfers.
REQ-016 Port stall_cnt  output  CNT_W: count of stalled occupied cycles.

Function
REQ-017 Storage SHALL consist of two DATA_W registers: main and skid.
REQ-018 The state machine SHALL have three states: EMPTY (0 entries), ONE (main valid) and TWO (main and skid valid).
REQ-019 in_fire SHALL be defined as in_valid & in_ready, and out_fire as out_valid & out_ready.
REQ-020 in_ready SHALL equal !stall & (state != TWO) and SHALL NOT depend on out_ready.
REQ-021 out_valid SHALL equal !stall & (state != EMPTY) and SHALL NOT depend on in_valid.
REQ-022 out_data SHALL equal main in states ONE and TWO, and NOP_VALUE in state EMPTY.
REQ-023 Transitions from EMPTY: on in_fire, main <= in_data and the next state is ONE; otherwise the state stays EMPTY.
REQ-024 Transitions from ONE:
  - in_fire and out_fire: main <= in_data; the state stays ONE.
  - in_fire only: skid <= in_data; the next state is TWO.
  - out_fire only: main <= NOP_VALUE; the next state is EMPTY.
  - neither: the state holds.
REQ-025 Transitions from TWO: on out_fire, main <= skid, skid <= NOP_VALUE and the next state is ONE; otherwise the state holds. in_fire is impossible in TWO.
REQ-026 Entries SHALL leave in the same order they were accepted; no entry SHALL be duplicated or dropped except by flush.
REQ-027 Latency SHALL be 1 cycle: data accepted at edge N is visible on out_data after edge N, provided no older entry is stored.
REQ-028 Throughput SHALL be one transfer per cycle when in_valid and out_ready are both continuously high.
REQ-029 While stall=1, the state, main and skid SHALL hold, and no fire SHALL occur on either side.
REQ-030 When flush=1 at an edge:
  - the state becomes EMPTY;
  - main and skid become NOP_VALUE;
  - any in_fire or out_fire that cycle is discarded and not counted.
REQ-031 flush SHALL have priority over stall.
REQ-032 occupancy SHALL read 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-033 xfer_cnt SHALL increment by 1 on each out_fire with flush=0.
REQ-034 stall_cnt SHALL increment by 1 on each cycle with stall=1, flush=0 and state != EMPTY.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and not wrap; flush SHALL NOT clear them.

Reset
REQ-036 When Rst=1 at an edge:
  - the state becomes EMPTY;
  - main and skid become NOP_VALUE;
  - xfer_cnt and stall_cnt become 0.
REQ-037 Rst SHALL override flush, stall and all handshakes.
REQ-038 During reset: out_valid=0, out_data=NOP_VALUE, occupancy=0.
REQ-039 in_ready SHALL equal !stall during reset and in the first cycle after it.
REQ-040 Rst asserted mid-operation SHALL discard stored entries exactly as flush does, and additionally clear the counters.

Verification
REQ-041 Streaming: in_valid=1 and out_ready=1 for 4 cycles with data 0x11,0x22,0x33,0x44 -> out_data is 0x11..0x44 on consecutive cycles, occupancy=1 throughout, xfer_cnt=4.
REQ-042 Backpressure: out_ready=0, then push 0xA and 0xB -> occupancy=2 and in_ready=0; then raise out_ready -> out_data is 0xA then 0xB, followed by EMPTY with out_data=0.
REQ-043 Stall: occupancy=2 and stall=1 for 3 cycles -> no fires, contents unchanged, stall_cnt=3; after release the entries drain in order.
REQ-044 Flush collision: state ONE holding 0x5, then flush=1 together with in_fire of 0x6 and out_fire -> next cycle occupancy=0, out_data=NOP_VALUE, xfer_cnt unchanged, and 0x6 never appears.
REQ-045 Saturation: CNT_W=2, 5 transfers -> xfer_cnt=3.
REQ-046 Reset mid-operation: occupancy=2 and xfer_cnt=7, then Rst=1 for 1 cycle -> occupancy=0, xfer_cnt=0, out_valid=0, and the next push appears after 1 cycle.
